sev_seg_scanner: RTL
====================

# sev_seg_scanner

Time-multiplexed seven-segment driver for the elevator status panel, generalising the fixed four-digit door display to NUM_DIGITS digits, one digit per floor. It scans the digits at a programmable refresh rate and shows the door glyph on the current floor's digit. The glyph blinks while the door is moving. It also shows a dash on every other floor with a pending call, with inter-digit blanking against ghosting. It sits between the elevator controller and the board's common-anode display pins.

## Interface
- NUM_DIGITS, 4, digit/floor count; legal range 2..16.
- REFRESH_DIV, 100000, clock cycles per digit slot; must be >= 2 and > BLANK_CYCLES.
- BLANK_CYCLES, 2, cycles at the start of each slot with every digit off; may be 0.
- BLINK_FRAMES, 64, full scan frames per blink half-period; must be >= 1.
- FLOOR_W (derived), max(1, clog2(NUM_DIGITS)).

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- floor_sel  in  FLOOR_W  current floor.
- door  in  1  1 = door open, 0 = door closed.
- door_moving  in  1  door is opening or closing.
- call_pending  in  NUM_DIGITS  bit k = hall call pending at floor k.
- segments  out  7  GFEDCBA, active-low, registered.
- select  out  NUM_DIGITS  active-low digit enables, registered; bit k drives digit k.
- frame_tick  out  1  one-cycle pulse, registered.

## Operation
- Glyphs (active-low):
  - OPEN = 7'b1000011.
  - CLOSED = 7'b0100011.
  - DASH = 7'b0111111.
  - BLANK = 7'b1111111.
- Counters:
  - refresh_cnt runs 0..REFRESH_DIV-1 and wraps.
  - digit_idx advances on each refresh_cnt wrap, 0..NUM_DIGITS-1, and wraps.
  - A frame is one full digit_idx cycle.
- Snapshot register holds {floor_sel, door, door_moving, call_pending}:
  - Loads live inputs on the last cycle of a frame (refresh_cnt = REFRESH_DIV-1 and digit_idx = NUM_DIGITS-1).
  - Held for the whole following frame, so input changes never tear a frame.
- Blink:
  - blink_cnt counts frames 0..BLINK_FRAMES-1.
  - blink_phase toggles when blink_cnt wraps.
  - Both update on the same edge as the snapshot load.
- Drive for state (refresh_cnt, digit_idx = k), evaluated in priority order:
  - If refresh_cnt < BLANK_CYCLES: select all ones, segments BLANK.
  - Otherwise select = all ones except bit k low, with segments chosen as:
    - k = snap floor and snap door_moving = 1 and blink_phase = 1: BLANK.
    - k = snap floor otherwise: OPEN if snap door = 1, else CLOSED.
    - snap call_pending[k] = 1: DASH.
    - otherwise: BLANK.
- A floor_sel value >= NUM_DIGITS matches no digit, so no door glyph is shown. Calls still display.
- A call pending on the current floor is hidden by the door glyph.
- Reset mid-scan:
  - Abandons the scan immediately.
  - Clears refresh_cnt, digit_idx, blink_cnt, blink_phase and the snapshot (floor 0, door closed, not moving, no calls).

## Timing
- Output register:
  - select, segments and frame_tick at edge t+1 reflect the counter and snapshot state during cycle t.
  - Latency is one cycle.
- Reset values:
  - select all ones, segments 7'b1111111, frame_tick 0.
  - All internal state is zero.
- First cycle after reset deassertion is the state refresh_cnt = 0, digit_idx = 0.
- First frame after reset displays the zero snapshot: digit 0 shows CLOSED, all others BLANK.
- Live inputs first appear in frame 2.
- frame_tick is 1 on exactly the output cycle that corresponds to state refresh_cnt = 0, digit_idx = 0, including after reset. Its period is NUM_DIGITS*REFRESH_DIV cycles.
- Exactly one select bit is low in any non-blanking cycle. None is low during blanking.
- Blink half-period is BLINK_FRAMES*NUM_DIGITS*REFRESH_DIV cycles. blink_phase = 0 (glyph visible) after reset.
- Each input is sampled once per frame. Pulses shorter than a frame that miss the sampling cycle are not displayed, by design.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2 (16-cycle frame).
- Reset/scan: hold reset 3 cycles, then release with idle inputs.
  - Outputs are all ones while reset is held and on the first edge after release.
  - Then per slot: one blank cycle followed by 3 cycles with select 1110/1101/1011/0111 in turn.
  - frame_tick pulses every 16 cycles.
  - Digit 0 shows 7'b0100011.
- Door glyph: floor_sel=2, door=1 applied mid-frame 1.
  - Frame 1 unchanged.
  - From frame 2, select 1011 carries 7'b1000011 and the other digits are 7'b1111111.
- Calls: call_pending=4'b1011, floor_sel=1, door=0.
  - From the next frame, digits 0 and 3 show 7'b0111111.
  - Digit 1 shows 7'b0100011 (call hidden).
  - Digit 2 shows blank.
- Blink: door_moving=1, floor_sel=3.
  - The digit-3 glyph is visible for 2 frames, blank for 2 frames, and repeats (32-cycle half-periods).
  - Deasserting door_moving restores a steady glyph from the next frame.
- Reset mid-operation: assert reset during digit 2 of a frame with floor_sel=3 and door=1.
  - Outputs go all ones the next edge.
  - After release the scan restarts at digit 0 with zero-snapshot content (7'b0100011 on digit 0).
- Snapshot stability: toggle door every cycle.
  - Segment values stay constant within each frame.
  - Each frame reflects the value sampled on the previous frame's last cycle.

Source files
------------

// File: rtl/sev_seg_scanner.sv
// rtl/sev_seg_scanner.sv - time-multiplexed seven-segment scanner for the elevator status panel
// Shows the door glyph on the current floor's digit and a dash on floors with pending calls.
module sev_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int FLOOR_W      = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOOR_W-1:0]    floor_sel,
  input  logic                  door,
  input  logic                  door_moving,
  input  logic [NUM_DIGITS-1:0] call_pending,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] select,
  output logic                  frame_tick
);

  localparam int CNT_W   = $clog2(REFRESH_DIV);
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] GLYPH_OPEN   = 7'b1000011;
  localparam logic [6:0] GLYPH_CLOSED = 7'b0100011;
  localparam logic [6:0] GLYPH_DASH   = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK  = 7'b1111111;

  logic [CNT_W-1:0]      refresh_cnt;
  logic [FLOOR_W-1:0]    digit_idx;
  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_phase;
  logic [FLOOR_W-1:0]    snap_floor;
  logic                  snap_door;
  logic                  snap_moving;
  logic [NUM_DIGITS-1:0] snap_calls;

  logic                  slot_end;
  logic                  frame_end;
  logic                  blanking;
  logic [NUM_DIGITS-1:0] next_select;
  logic [6:0]            next_segments;

  assign slot_end  = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (digit_idx == FLOOR_W'(NUM_DIGITS - 1));
  assign blanking  = (int'({1'b0, refresh_cnt}) < BLANK_CYCLES);

  // A floor_sel beyond the last digit never equals digit_idx, so only calls show.
  always_comb begin
    next_select   = '1;
    next_segments = GLYPH_BLANK;
    if (!blanking) begin
      next_select = ~(NUM_DIGITS'(1) << digit_idx);
      if (snap_floor == digit_idx) begin
        if (snap_moving && blink_phase) next_segments = GLYPH_BLANK;
        else                            next_segments = snap_door ? GLYPH_OPEN : GLYPH_CLOSED;
      end else if (snap_calls[digit_idx]) begin
        next_segments = GLYPH_DASH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_floor  <= '0;
      snap_door   <= 1'b0;
      snap_moving <= 1'b0;
      snap_calls  <= '0;
      select      <= '1;
      segments    <= GLYPH_BLANK;
      frame_tick  <= 1'b0;
    end else begin
      select     <= next_select;
      segments   <= next_segments;
      frame_tick <= (refresh_cnt == '0) && (digit_idx == '0);

      if (slot_end) begin
        refresh_cnt <= '0;
        digit_idx   <= frame_end ? '0 : digit_idx + FLOOR_W'(1);
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end

      // Inputs are captured once per frame so a frame never mixes two input states.
      if (frame_end) begin
        snap_floor  <= floor_sel;
        snap_door   <= door;
        snap_moving <= door_moving;
        snap_calls  <= call_pending;
        if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

endmodule
